axi_read_mux: RTL and testbench

Parametrised AXI3 read-channel master that arbitrates NUM_PORTS internal read requesters (MEM, IF, future cache refill) onto one AR/R channel pair. Supports bursts up to 16 beats and one outstanding transaction per requester, so up to NUM_PORTS reads may be in flight at once. Responses are routed back by RID. Sits between the CPU pipeline/caches and the external AXI interconnect. Supersedes the single-outstanding, two-client read adapter.

---
 rtl/axi_read_mux_pkg.sv | 20 ++
 rtl/axi_rd_arbiter.sv | 56 +++++
 rtl/axi_read_mux.sv | 173 +++++++++++++++++
 tb/tb_axi_read_mux.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_mux_pkg.sv
// Shared AXI3 encodings and AR state codes for the multi-port read master.
package axi_read_mux_pkg;

   localparam int         ID_W             = 4;

   localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
   localparam logic [1:0] AXI_LOCK_NORMAL  = 2'b00;
   localparam logic [3:0] AXI_CACHE_NONE   = 4'b0000;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b001;

   // AR channel state codes
   localparam logic [0:0] AR_IDLE          = 1'b0;
   localparam logic [0:0] AR_SEND          = 1'b1;

   // arsize encoding for a given data bus width in bits
   function automatic logic [2:0] axi_size(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/axi_rd_arbiter.sv
// Fixed-priority or round-robin arbiter over the eligible requester vector.
// The round-robin pointer lives here and advances past the winner whenever
// the grant is taken (enable high with a non-empty eligible vector).
module axi_rd_arbiter
   import axi_read_mux_pkg::*;
#(
   parameter int N       = 2,
   parameter int RR_MODE = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    eligible,
   input  logic            enable,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any
);

   logic [ID_W-1:0] ptr_q;
   logic [15:0]     elig_pad;
   logic [4:0]      cand;

   assign elig_pad = 16'(eligible);

   // Scan from index 0 (fixed) or from the pointer with wrap (round-robin)
   always_comb begin
      any       = 1'b0;
      grant_idx = '0;
      grant     = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = 5'(i);
         if (RR_MODE != 0) begin
            cand = 5'(ptr_q) + 5'(i);
            if (cand >= 5'(N)) cand = cand - 5'(N);
         end
         if (!any && elig_pad[cand[3:0]]) begin
            any       = 1'b1;
            grant_idx = cand[3:0];
         end
      end
      for (int p = 0; p < N; p++) begin
         grant[p] = any && (grant_idx == ID_W'(p));
      end
   end

   // Pointer moves to the port after the one just granted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
      end else if ((RR_MODE != 0) && enable && any) begin
         ptr_q <= (grant_idx == ID_W'(N - 1)) ? '0 : grant_idx + ID_W'(1);
      end
   end

endmodule

// File: rtl/axi_read_mux.sv
// AXI3 read master multiplexing NUM_PORTS requesters onto one AR/R pair.
// Each requester may have one read outstanding; R beats are routed by RID.
//
// Handshakes: every channel transfers on a cycle where valid & ready are both
// high. A valid, once raised, is held with its payload stable until the
// transfer; ready may depend combinationally on valid and may toggle freely.
module axi_read_mux
   import axi_read_mux_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RR_MODE   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PORTS-1:0]      req_valid,
   output logic [NUM_PORTS-1:0]      req_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS*4-1:0]    req_len,
   output logic [NUM_PORTS-1:0]      resp_valid,
   input  logic [NUM_PORTS-1:0]      resp_ready,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_last,
   output logic                      resp_err,
   output logic                      proto_err,
   output logic [ID_W-1:0]           arid,
   output logic [ADDR_W-1:0]         araddr,
   output logic [3:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic [1:0]                arlock,
   output logic [3:0]                arcache,
   output logic [2:0]                arprot,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [ID_W-1:0]           rid,
   input  logic [DATA_W-1:0]         rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [0:0]                dbg_ar_state,
   output logic [NUM_PORTS-1:0]      dbg_busy
);

   logic [0:0]           ar_state_q;
   logic [NUM_PORTS-1:0] busy_q;
   logic [3:0]           cnt_q [NUM_PORTS];

   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant;
   logic [ID_W-1:0]      grant_idx;
   logic                 grant_any;
   logic                 ar_accept;
   logic [ADDR_W-1:0]    sel_addr;
   logic [3:0]           sel_len;

   logic                 hit;
   logic [NUM_PORTS-1:0] hit_oh;
   logic [3:0]           sel_cnt;
   logic                 sel_rdy;
   logic                 beat;
   logic                 beat_err;
   logic                 unused_rresp;

   assign arsize       = axi_size(DATA_W);
   assign arburst      = AXI_BURST_INCR;
   assign arlock       = AXI_LOCK_NORMAL;
   assign arcache      = AXI_CACHE_NONE;
   assign arprot       = AXI_PROT_DEFAULT;
   assign dbg_ar_state = ar_state_q;
   assign dbg_busy     = busy_q;

   // A port with a read in flight cannot request again until its last beat
   assign eligible  = req_valid & ~busy_q;
   assign ar_accept = (ar_state_q == AR_IDLE) && grant_any;
   assign req_ready = (ar_state_q == AR_IDLE) ? grant : '0;

   axi_rd_arbiter #(
      .N       (NUM_PORTS),
      .RR_MODE (RR_MODE)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .eligible  (eligible),
      .enable    (ar_state_q == AR_IDLE),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   // Pick the granted port's address and length
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_addr = req_addr[p*ADDR_W +: ADDR_W];
            sel_len  = req_len[p*4 +: 4];
         end
      end
   end

   // Decode RID against the busy ports
   always_comb begin
      hit     = 1'b0;
      hit_oh  = '0;
      sel_cnt = '0;
      sel_rdy = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if ((rid == ID_W'(p)) && busy_q[p]) begin
            hit       = 1'b1;
            hit_oh[p] = 1'b1;
            sel_cnt   = cnt_q[p];
            sel_rdy   = resp_ready[p];
         end
      end
   end

   // Beats for no busy port are swallowed so the interconnect never stalls
   assign rready       = hit ? sel_rdy : rvalid;
   assign resp_valid   = rvalid ? hit_oh : '0;
   assign resp_data    = rdata;
   assign resp_last    = rlast;
   assign resp_err     = rresp[1];
   assign unused_rresp = rresp[0];
   assign beat         = rvalid && rready;
   assign beat_err     = beat && (hit ? (rlast != (sel_cnt == 4'd0)) : 1'b1);

   // AR channel: capture the winner, then hold it until arready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ar_state_q <= AR_IDLE;
         arvalid    <= 1'b0;
         araddr     <= '0;
         arlen      <= '0;
         arid       <= '0;
      end else if (ar_state_q == AR_IDLE) begin
         if (grant_any) begin
            araddr     <= sel_addr;
            arlen      <= sel_len;
            arid       <= grant_idx;
            arvalid    <= 1'b1;
            ar_state_q <= AR_SEND;
         end
      end else if (arready) begin
         arvalid    <= 1'b0;
         ar_state_q <= AR_IDLE;
      end
   end

   // Per-port busy flag and remaining-beat counter, plus the error pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q    <= '0;
         proto_err <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      end else begin
         proto_err <= beat_err;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (ar_accept && grant[p]) begin
               busy_q[p] <= 1'b1;
               cnt_q[p]  <= sel_len;
            end else if (beat && hit_oh[p]) begin
               if (rlast) busy_q[p] <= 1'b0;
               else if (cnt_q[p] != 4'd0) cnt_q[p] <= cnt_q[p] - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_read_mux.sv
// Directed bench for axi_read_mux: a fixed-priority instance and a
// round-robin instance share all inputs; each is checked on its own outputs.
module tb_axi_read_mux;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [NP-1:0] req_valid, resp_ready;
   logic [NP*AW-1:0] req_addr;
   logic [NP*4-1:0]  req_len;
   logic          arready, rlast, rvalid;
   logic [3:0]    rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;

   // fixed-priority instance outputs
   logic [NP-1:0] req_ready, resp_valid, dbg_busy;
   logic [DW-1:0] resp_data;
   logic          resp_last, resp_err, proto_err, arvalid, rready;
   logic [3:0]    arid, arlen, arcache;
   logic [AW-1:0] araddr;
   logic [2:0]    arsize, arprot;
   logic [1:0]    arburst, arlock;
   logic [0:0]    dbg_state;

   // round-robin instance outputs
   logic [NP-1:0] req_ready_r, resp_valid_r, dbg_busy_r;
   logic [DW-1:0] resp_data_r;
   logic          resp_last_r, resp_err_r, proto_err_r, arvalid_r, rready_r;
   logic [3:0]    arid_r, arlen_r, arcache_r;
   logic [AW-1:0] araddr_r;
   logic [2:0]    arsize_r, arprot_r;
   logic [1:0]    arburst_r, arlock_r;
   logic [0:0]    dbg_state_r;

   int n_vec = 0;
   int n_bad = 0;

   axi_read_mux #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
      .resp_err(resp_err), .proto_err(proto_err), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready), .dbg_ar_state(dbg_state), .dbg_busy(dbg_busy)
   );

   axi_read_mux #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut_rr (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_r),
      .req_addr(req_addr), .req_len(req_len), .resp_valid(resp_valid_r),
      .resp_ready(resp_ready), .resp_data(resp_data_r), .resp_last(resp_last_r),
      .resp_err(resp_err_r), .proto_err(proto_err_r), .arid(arid_r), .araddr(araddr_r),
      .arlen(arlen_r), .arsize(arsize_r), .arburst(arburst_r), .arlock(arlock_r),
      .arcache(arcache_r), .arprot(arprot_r), .arvalid(arvalid_r), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready_r), .dbg_ar_state(dbg_state_r), .dbg_busy(dbg_busy_r)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      req_valid  = '0;
      req_addr   = '0;
      req_len    = '0;
      resp_ready = '0;
      arready    = 1'b0;
      rid        = '0;
      rdata      = '0;
      rresp      = 2'b00;
      rlast      = 1'b0;
      rvalid     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Request on one port, check the AR it produces, hold arready low ar_delay cycles
   task automatic issue(input int port, input logic [31:0] addr, input logic [3:0] len,
                        input int ar_delay);
      logic [NP-1:0] one;
      one = '0;
      one[port] = 1'b1;
      req_valid = one;
      req_addr[port*AW +: AW] = addr;
      req_len[port*4 +: 4]    = len;
      #1 chk("req_ready", req_ready, one);
      @(negedge clk);
      req_valid = '0;
      chk("arvalid_up", arvalid, 1);
      chk("arid", arid, port);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, len);
      #1 chk("req_ready_send", req_ready, 0);
      for (int i = 0; i < ar_delay; i++) begin
         @(negedge clk);
         chk("arvalid_hold", arvalid, 1);
         chk("araddr_hold", araddr, addr);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("arvalid_down", arvalid, 0);
   endtask

   // Present one R beat; check routing now and the error pulse a cycle later
   task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic l,
                       input logic [NP-1:0] rr, input logic [1:0] rsp,
                       input logic [NP-1:0] exp_rv, input logic exp_rrdy,
                       input logic exp_perr);
      rid = id; rdata = d; rlast = l; rresp = rsp; resp_ready = rr; rvalid = 1'b1;
      #1;
      chk("resp_valid", resp_valid, exp_rv);
      chk("rready", rready, exp_rrdy);
      if (exp_rv != '0) begin
         chk("resp_data", resp_data, d);
         chk("resp_last", resp_last, l);
         chk("resp_err", resp_err, rsp[1]);
      end
      @(negedge clk);
      rvalid = 1'b0;
      resp_ready = '0;
      chk("proto_err", proto_err, exp_perr);
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      #2;
      // reset state
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_arid", arid, 0);
      chk("rst_arlen", arlen, 0);
      chk("rst_busy", dbg_busy, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_rready", rready, 0);
      chk("arsize", arsize, 3'd2);
      chk("arburst", arburst, 2'b01);
      chk("arlock", arlock, 0);
      chk("arcache", arcache, 0);
      chk("arprot", arprot, 3'b001);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // single beat read on port 0, slow arready
      issue(0, 32'h0000_1000, 4'd0, 2);
      chk("t1_busy", dbg_busy, 2'b01);
      beat(4'd0, 32'hDEAD_BEEF, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
      chk("t1_busy_clr", dbg_busy, 2'b00);
      #1 chk("t1_resp_gone", resp_valid, 2'b00);
      @(negedge clk);

      // simultaneous requests, fixed priority; responses out of order
      req_valid = 2'b11;
      req_addr  = {32'h0000_3000, 32'h0000_2000};
      req_len   = 8'h00;
      #1 chk("t2_req_ready", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b10;
      chk("t2_ar0_valid", arvalid, 1);
      chk("t2_ar0_id", arid, 0);
      chk("t2_ar0_addr", araddr, 32'h0000_2000);
      arready = 1'b1;
      #1 chk("t2_req_ready_send", req_ready, 2'b00);
      @(negedge clk);
      chk("t2_ar_gap", arvalid, 0);
      #1 chk("t2_req_ready_p1", req_ready, 2'b10);
      @(negedge clk);
      req_valid = 2'b00;
      chk("t2_ar1_valid", arvalid, 1);
      chk("t2_ar1_id", arid, 1);
      chk("t2_ar1_addr", araddr, 32'h0000_3000);
      @(negedge clk);
      arready = 1'b0;
      chk("t2_ar1_done", arvalid, 0);
      chk("t2_busy_both", dbg_busy, 2'b11);
      beat(4'd1, 32'h1111_1111, 1'b1, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0);
      beat(4'd0, 32'h2222_2222, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0);
      chk("t2_busy_clr", dbg_busy, 2'b00);

      // interleaved burst on port 1 with backpressure and a slave error beat
      issue(1, 32'h0000_4000, 4'd3, 0);
      issue(0, 32'h0000_5000, 4'd0, 0);
      beat(4'd1, 32'hA000_0000, 1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
      beat(4'd1, 32'hA000_0001, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
      beat(4'd1, 32'hA000_0001, 1'b0, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
      beat(4'd0, 32'hB000_0000, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
      chk("t4_busy_mid", dbg_busy, 2'b10);
      beat(4'd1, 32'hA000_0002, 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0);
      beat(4'd1, 32'hA000_0003, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0);
      chk("t4_busy_clr", dbg_busy, 2'b00);

      // early rlast, then a beat with an out-of-range id
      issue(0, 32'h0000_6000, 4'd3, 0);
      beat(4'd0, 32'hC000_0000, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
      beat(4'd0, 32'hC000_0001, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b1);
      chk("t5_busy_clr", dbg_busy, 2'b00);
      beat(4'd5, 32'hC000_0002, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      chk("t5_perr_drop", proto_err, 0);

      // round-robin grants 0,1,0 with ports freed between grants
      do_reset();
      req_valid = 2'b11;
      req_addr  = {32'h0000_9100, 32'h0000_9000};
      req_len   = 8'h00;
      #1 chk("rr_req_ready_a", req_ready_r, 2'b01);
      @(negedge clk);
      chk("rr_ar_a_valid", arvalid_r, 1);
      chk("rr_ar_a_id", arid_r, 0);
      rid = 4'd0; rdata = 32'h5555_0000; rlast = 1'b1; resp_ready = 2'b11; rvalid = 1'b1;
      #1 chk("rr_resp_a", resp_valid_r, 2'b01);
      @(negedge clk);
      rvalid = 1'b0;
      chk("rr_busy_a", dbg_busy_r, 2'b00);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("rr_ar_a_done", arvalid_r, 0);
      #1 chk("rr_req_ready_b", req_ready_r, 2'b10);
      chk("fp_req_ready_b", req_ready, 2'b01);
      @(negedge clk);
      chk("rr_ar_b_valid", arvalid_r, 1);
      chk("rr_ar_b_id", arid_r, 1);
      chk("rr_ar_b_addr", araddr_r, 32'h0000_9100);
      rid = 4'd1; rdata = 32'h5555_0001; rlast = 1'b1; rvalid = 1'b1;
      #1 chk("rr_resp_b", resp_valid_r, 2'b10);
      @(negedge clk);
      rvalid = 1'b0;
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("rr_ar_b_done", arvalid_r, 0);
      #1 chk("rr_req_ready_c", req_ready_r, 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      chk("rr_ar_c_valid", arvalid_r, 1);
      chk("rr_ar_c_id", arid_r, 0);

      // asynchronous reset with an AR pending and a burst mid-flight
      do_reset();
      issue(0, 32'h0000_7000, 4'd3, 0);
      beat(4'd0, 32'hE000_0000, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0);
      req_valid = 2'b10;
      req_addr[AW +: AW] = 32'h0000_7100;
      @(negedge clk);
      req_valid = 2'b00;
      chk("t6_arvalid_pre", arvalid, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_arvalid_async", arvalid, 0);
      chk("t6_busy_async", dbg_busy, 2'b00);
      chk("t6_state_async", dbg_state, 0);
      chk("t6_araddr_async", araddr, 0);
      @(negedge clk);
      reset = 1'b1;
      req_valid = 2'b01;
      req_addr[0 +: AW] = 32'h0000_8000;
      req_len = 8'h00;
      #1 chk("t6_req_ready", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      chk("t6_arvalid", arvalid, 1);
      chk("t6_araddr", araddr, 32'h0000_8000);
      chk("t6_arid", arid, 0);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
